// File: rtl/apb3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb3_pkg
//  Description : Shared types and sizing helpers for the queued APB3
//                requester: FSM state encoding, counter/pointer widths and
//                the packed layouts of command and response FIFO entries.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb3_pkg;

    // APB3 requester phases, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } apb3_state_e;

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 32'd1;
    endfunction

    // Pointer width; a single-entry FIFO still needs a one-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

    // Command entry layout: {write, addr, wdata}.
    function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
        return 32'd1 + aw + dw;
    endfunction

    // Response entry layout: {rdata, error, timeout}.
    function automatic int unsigned rsp_width(input int unsigned dw);
        return dw + 32'd2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb3_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : apb3_sync_fifo
//  Description : Single-clock FIFO with synchronous reset, full/empty flags
//                and an occupancy count. Push and pop in the same cycle are
//                both honoured; the head entry is visible combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb3_sync_fifo
    import apb3_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_wdata,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [cnt_width(DEPTH)-1:0]   o_count
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    generate
        if (!is_pow2(DEPTH)) begin : g_bad_depth
            $error("apb3_sync_fifo: DEPTH must be a power of two");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Pointer advance with explicit wrap so non-full-range pointers stay in bounds.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 32'd1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb3_requester_queued.sv
`default_nettype none
// ============================================================================
//  Module      : apb3_requester_queued
//  Description : APB3 requester with a command FIFO in front of the bus FSM
//                and a response FIFO behind it. A response credit check
//                before each SETUP guarantees every completion has room, so
//                pready is never back-pressured. Optional back-to-back issue
//                and a per-transfer ACCESS timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb3_requester_queued
    import apb3_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned RSP_DEPTH      = 2,
    parameter int unsigned BACK_TO_BACK   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr,
    output logic                  busy
);

    localparam int unsigned CMD_W  = cmd_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned RSP_W  = rsp_width(DATA_WIDTH);
    localparam int unsigned CMD_CW = cnt_width(CMD_DEPTH);
    localparam int unsigned RSP_CW = cnt_width(RSP_DEPTH);
    localparam int unsigned RSP_SW = RSP_CW + 32'd1;
    localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 32'd1;

    generate
        if ((DATA_WIDTH < 32'd8) || (DATA_WIDTH > 32'd64)) begin : g_bad_dw
            $error("apb3_requester_queued: DATA_WIDTH must be 8..64");
        end
        if (CMD_DEPTH < 32'd2) begin : g_bad_cmd_depth
            $error("apb3_requester_queued: CMD_DEPTH must be at least 2");
        end
    endgenerate

    apb3_state_e         r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;

    logic                w_cmd_push;
    logic                w_cmd_empty;
    logic                w_cmd_full;
    logic [CMD_CW-1:0]   w_cmd_count;
    logic [CMD_CW-1:0]   w_cmd_next;
    logic [CMD_W-1:0]    w_cmd_head;
    logic                w_head_write;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_wdata;

    logic                w_rsp_push;
    logic                w_rsp_pop;
    logic                w_rsp_empty;
    logic                w_rsp_full;
    logic [RSP_CW-1:0]   w_rsp_count;
    logic [RSP_W-1:0]    w_rsp_wdata;
    logic [RSP_W-1:0]    w_rsp_head;

    logic                w_in_access;
    logic [RSP_SW-1:0]   w_credit_sum;
    logic                w_credit_ok;
    logic                w_timeout_hit;
    logic                w_issue;

    assign w_cmd_push   = req_valid && req_ready;
    assign w_head_write = w_cmd_head[CMD_W-1];
    assign w_head_addr  = w_cmd_head[DATA_WIDTH +: ADDR_WIDTH];
    assign w_head_wdata = w_cmd_head[DATA_WIDTH-1:0];

    apb3_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (pclk),
        .rst     (preset),
        .i_push  (w_cmd_push),
        .i_wdata ({req_write, req_addr, req_wdata}),
        .i_pop   (w_issue),
        .o_rdata (w_cmd_head),
        .o_full  (w_cmd_full),
        .o_empty (w_cmd_empty),
        .o_count (w_cmd_count)
    );

    assign w_rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_valid   = !w_rsp_empty;
    assign rsp_rdata   = w_rsp_head[RSP_W-1:2];
    assign rsp_error   = w_rsp_head[1];
    assign rsp_timeout = w_rsp_head[0];

    apb3_sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (pclk),
        .rst     (preset),
        .i_push  (w_rsp_push),
        .i_wdata (w_rsp_wdata),
        .i_pop   (w_rsp_pop),
        .o_rdata (w_rsp_head),
        .o_full  (w_rsp_full),
        .o_empty (w_rsp_empty),
        .o_count (w_rsp_count)
    );

    // Responses already stored (net of this cycle's pop) plus the transfer on the bus.
    assign w_in_access   = (r_state == S_ACCESS);
    assign w_credit_sum  = {1'b0, w_rsp_count} - RSP_SW'(w_rsp_pop) + RSP_SW'(r_state != S_IDLE);
    assign w_credit_ok   = (w_credit_sum < RSP_SW'(RSP_DEPTH));
    assign w_timeout_hit = (TIMEOUT_CYCLES != 32'd0) && w_in_access && !pready &&
                           (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 32'd1));
    assign w_issue       = !w_cmd_empty && w_credit_ok &&
                           ((r_state == S_IDLE) ||
                            (w_in_access && pready && (BACK_TO_BACK != 32'd0)));
    assign w_rsp_push    = w_in_access && (pready || w_timeout_hit);
    assign busy          = (r_state != S_IDLE) || !w_cmd_empty || !w_rsp_empty;

    // Response entry: completion data (zeroed for writes and errors) or a timeout marker.
    always_comb begin
        w_rsp_wdata = '0;
        if (pready) begin
            w_rsp_wdata = {((!pwrite && !pslverr) ? prdata : {DATA_WIDTH{1'b0}}), pslverr, 1'b0};
        end else begin
            w_rsp_wdata = {{DATA_WIDTH{1'b0}}, 1'b1, 1'b1};
        end
    end

    // Registered ready: reflects whether the FIFO will have space after this edge.
    assign w_cmd_next = w_cmd_count + CMD_CW'(w_cmd_push) - CMD_CW'(w_issue);
    always_ff @(posedge pclk) begin
        if (preset) begin
            req_ready <= 1'b0;
        end else begin
            req_ready <= (w_cmd_next != CMD_CW'(CMD_DEPTH));
        end
    end

    // APB phase sequencer; paddr/pwrite/pwdata double as the issue register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state    <= S_SETUP;
                        r_wait_cnt <= '0;
                        psel       <= 1'b1;
                        penable    <= 1'b0;
                        pwrite     <= w_head_write;
                        paddr      <= w_head_addr;
                        pwdata     <= w_head_wdata;
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                    penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (pready && w_issue) begin
                        r_state    <= S_SETUP;
                        r_wait_cnt <= '0;
                        penable    <= 1'b0;
                        pwrite     <= w_head_write;
                        paddr      <= w_head_addr;
                        pwdata     <= w_head_wdata;
                    end else if (pready || w_timeout_hit) begin
                        r_state <= S_IDLE;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        pwrite  <= 1'b0;
                        paddr   <= '0;
                        pwdata  <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb3_requester_queued.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb3_requester_queued
//  Description : Self-checking bench for apb3_requester_queued with an APB3
//                completer model, a bus monitor and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb3_requester_queued;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic        pclk = 1'b0;
    logic        preset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr, busy;

    int n_total = 0;
    int n_bad   = 0;
    int stall_cycles = 0;
    int cmp_k = 0;
    int setup_cnt = 0;
    int psel_run = 0;
    int max_psel_run = 0;
    int acc_run = 0;
    int last_acc_len = 0;

    cmd_t        apb_q [$];
    logic [33:0] sb_q  [$];
    cmd_t        cur;
    logic [33:0] cons_exp;

    always #5 pclk = ~pclk;

    apb3_requester_queued #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .CMD_DEPTH      (4),
        .RSP_DEPTH      (2),
        .BACK_TO_BACK   (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr),
        .busy        (busy)
    );

    // Completer read data as a function of address.
    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a ^ 32'h5A5A_C3C3) + 32'h0000_0101;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // APB3 completer: region 0xE errors, region 0xF never answers, stall_cycles wait states.
    initial begin
        pready  = 1'b0;
        prdata  = '1;
        pslverr = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            if (psel && penable) begin
                pready  = (cmp_k >= stall_cycles) && (paddr[31:28] != 4'hF);
                prdata  = rd_model(paddr);
                pslverr = pready && (paddr[31:28] == 4'hE);
                cmp_k++;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = '1;
                cmp_k   = 0;
            end
        end
    end

    // Bus monitor: transfer order and stability, idle zeros, phase run lengths.
    initial begin
        forever begin
            @(negedge pclk);
            if (preset) begin
                psel_run = 0;
                acc_run  = 0;
            end else begin
                if (psel && !penable) begin
                    setup_cnt++;
                    if (apb_q.size() == 0) chk("apb_unexpected_setup", 64'd1, 64'd0);
                    else cur = apb_q.pop_front();
                end
                if (psel) begin
                    chk("apb_paddr", paddr, cur.addr);
                    chk("apb_pwrite", pwrite, cur.write);
                    if (cur.write) chk("apb_pwdata", pwdata, cur.wdata);
                    psel_run++;
                    if (psel_run > max_psel_run) max_psel_run = psel_run;
                end else begin
                    psel_run = 0;
                    chk("idle_ctl", {penable, pwrite}, 64'd0);
                    chk("idle_paddr", paddr, 64'd0);
                    chk("idle_pwdata", pwdata, 64'd0);
                end
                if (psel && penable) acc_run++;
                else if (acc_run > 0) begin
                    last_acc_len = acc_run;
                    acc_run = 0;
                end
            end
        end
    end

    // Response consumer: compare each handshake against the scoreboard head.
    initial begin
        forever begin
            @(negedge pclk);
            if (!preset && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
                else begin
                    cons_exp = sb_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, cons_exp[33:2]);
                    chk("rsp_error", rsp_error, cons_exp[1]);
                    chk("rsp_timeout", rsp_timeout, cons_exp[0]);
                end
            end
        end
    end

    // Present one command; returns #1 after the accepting edge with req_valid still high.
    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic rdy;
        bit   done;
        logic to, err;
        cmd_t c;
        done = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge pclk);
            rdy = req_ready;
            @(posedge pclk);
            if (rdy) done = 1'b1;
        end
        chk("req_accepted", done, 64'd1);
        if (done) begin
            to  = (a[31:28] == 4'hF);
            err = (a[31:28] == 4'hE) || to;
            c.write = wr;
            c.addr  = a;
            c.wdata = d;
            apb_q.push_back(c);
            sb_q.push_back({((!wr && !err) ? rd_model(a) : 32'd0), err, to});
        end
        #1;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge pclk);
            if (!busy && sb_q.size() == 0) ok = 1'b1;
        end
        chk("idle_reached", ok, 64'd1);
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  s0;
        bit  found;
        preset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_psel", psel, 64'd0);
        chk("rst_penable", penable, 64'd0);
        chk("rst_req_ready", req_ready, 64'd0);
        chk("rst_rsp_valid", rsp_valid, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_paddr", paddr, 64'd0);
        @(posedge pclk);
        #1;
        preset = 1'b0;

        // Single write, immediate pready: latency E0 -> E1 SETUP -> E2 ACCESS -> E3 rsp
        rsp_ready = 1'b1;
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        req_valid = 1'b0;
        @(negedge pclk); chk("wr_e0_psel", psel, 64'd0);
        @(negedge pclk); chk("wr_e1_psel", psel, 64'd1); chk("wr_e1_penable", penable, 64'd0);
        @(negedge pclk); chk("wr_e2_psel", psel, 64'd1); chk("wr_e2_penable", penable, 64'd1);
        @(negedge pclk); chk("wr_e3_rsp_valid", rsp_valid, 64'd1); chk("wr_e3_psel", psel, 64'd0);
        wait_idle(20);
        chk("wr_access_len", last_acc_len, 64'd1);

        // Four queued reads issue back-to-back
        max_psel_run = 0;
        for (int i = 0; i < 4; i++) send(1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0);
        req_valid = 1'b0;
        wait_idle(40);
        chk("b2b_psel_run", max_psel_run, 64'd8);

        // Five wait states stretch ACCESS to six cycles
        stall_cycles = 5;
        send(1'b1, 32'h0000_0020, 32'hCAFE_0001);
        req_valid = 1'b0;
        wait_idle(40);
        chk("stall_access_len", last_acc_len, 64'd6);
        stall_cycles = 0;

        // Completer never answers: abort after TIMEOUT_CYCLES ACCESS cycles
        send(1'b0, 32'hF000_0040, 32'h0);
        req_valid = 1'b0;
        wait_idle(60);
        chk("timeout_access_len", last_acc_len, 64'd16);

        // Response credit stalls issue; one pop releases the next SETUP
        rsp_ready = 1'b0;
        s0 = setup_cnt;
        send(1'b0, 32'h0000_0200, 32'h0);
        send(1'b0, 32'hE000_0204, 32'h0);
        send(1'b0, 32'h0000_0208, 32'h0);
        send(1'b0, 32'h0000_020C, 32'h0);
        req_valid = 1'b0;
        repeat (20) @(posedge pclk);
        @(negedge pclk);
        chk("credit_xfers", setup_cnt - s0, 64'd2);
        chk("credit_psel_stalled", psel, 64'd0);
        chk("credit_rsp_valid", rsp_valid, 64'd1);
        @(posedge pclk); #1; rsp_ready = 1'b1;
        @(posedge pclk); #1; rsp_ready = 1'b0;
        @(negedge pclk);
        chk("credit_resume_psel", psel, 64'd1);
        chk("credit_resume_penable", penable, 64'd0);
        @(posedge pclk); #1;
        rsp_ready = 1'b1;
        wait_idle(60);

        // Reset during ACCESS drops the transfer without a response
        stall_cycles = 30;
        send(1'b0, 32'h0000_0300, 32'h0);
        req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge pclk);
            if (psel && penable) found = 1'b1;
        end
        chk("rst_mid_in_access", found, 64'd1);
        @(posedge pclk); #1;
        preset = 1'b1;
        sb_q.delete();
        apb_q.delete();
        @(posedge pclk);
        @(negedge pclk);
        chk("rst_mid_psel", psel, 64'd0);
        chk("rst_mid_penable", penable, 64'd0);
        chk("rst_mid_req_ready", req_ready, 64'd0);
        chk("rst_mid_rsp_valid", rsp_valid, 64'd0);
        @(posedge pclk); #1;
        preset = 1'b0;
        stall_cycles = 0;
        repeat (8) @(posedge pclk);
        @(negedge pclk);
        chk("rst_mid_no_rsp", rsp_valid, 64'd0);
        chk("rst_mid_busy", busy, 64'd0);
        @(posedge pclk); #1;

        // Recovery traffic after reset
        send(1'b0, 32'h0000_0400, 32'h0);
        send(1'b1, 32'h0000_0404, 32'h1234_5678);
        req_valid = 1'b0;
        wait_idle(40);

        chk("sb_drained", sb_q.size(), 64'd0);
        chk("apb_drained", apb_q.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
